// File: rtl/timer_nch.sv
// timer_nch: CH independent down-counting timers with stop, one-shot, auto-reload and square-wave modes.
// Define TIMER_NCH_IRQ_EN to build the per-channel sticky interrupt flags; otherwise irq_o is tied low.
module timer_nch #(
  parameter int CH = 3,
  parameter int W  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [$clog2(CH)-1:0] ch_sel,
  input  logic                  reg_sel,
  input  logic [W-1:0]          wdata,
  input  logic [CH-1:0]         tick_i,
  output logic [CH*W-1:0]       count_o,
  output logic [CH-1:0]         out_o,
  output logic [CH-1:0]         irq_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {M_STOP, M_ONE, M_AUTO, M_SQR} mode_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t       st;
    mode_t        mode;
    logic [W-1:0] cnt;
    logic [W-1:0] load;
    logic         tick_q;
    logic         out_q;
    logic         wr_load;
    logic         wr_ctrl;
    logic         cnt_evt;
    logic         term;

    always_comb begin
      wr_load = we && !reg_sel && (32'(ch_sel) == g);
      wr_ctrl = we &&  reg_sel && (32'(ch_sel) == g);
      // Any write to this channel swallows a coincident tick edge.
      cnt_evt = (st == RUN) && tick_i[g] && !tick_q && !wr_load && !wr_ctrl && (load != '0);
      term    = cnt_evt && (cnt == ONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        st     <= IDLE;
        mode   <= M_STOP;
        cnt    <= '0;
        load   <= '0;
        tick_q <= 1'b0;
        out_q  <= 1'b0;
      end else begin
        tick_q <= tick_i[g];
        // Auto-reload output is a single-clk pulse; later assignments override this.
        if (mode == M_AUTO) out_q <= 1'b0;
        if (wr_load) begin
          load  <= wdata;
          cnt   <= wdata;
          out_q <= 1'b0;
          st    <= (mode != M_STOP) ? RUN : IDLE;
        end else if (wr_ctrl) begin
          mode <= mode_t'(wdata[1:0]);
          st   <= (wdata[1:0] != 2'b00) ? RUN : IDLE;
        end else if (term) begin
          case (mode)
            M_ONE: begin
              cnt   <= '0;
              st    <= DONE;
              out_q <= 1'b1;
            end
            M_AUTO: begin
              cnt   <= load;
              out_q <= 1'b1;
            end
            M_SQR: begin
              cnt   <= load;
              out_q <= ~out_q;
            end
            default: st <= IDLE;
          endcase
        end else if (cnt_evt) begin
          cnt <= cnt - ONE;
        end
      end
    end

`ifdef TIMER_NCH_IRQ_EN
    logic ie;
    logic term_q;
    logic irq_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        ie     <= 1'b0;
        term_q <= 1'b0;
        irq_q  <= 1'b0;
      end else begin
        if (wr_ctrl) ie <= wdata[2];
        term_q <= term && ie;
        // A pending set beats a coincident clear.
        irq_q  <= (irq_q && !(wr_ctrl && wdata[3])) || term_q;
      end
    end

    assign irq_o[g] = irq_q;
`else
    assign irq_o[g] = 1'b0;
`endif

    assign out_o[g]           = out_q;
    assign count_o[g*W +: W] = cnt;
  end

endmodule

// File: tb/tb_timer_nch.sv
// Self-checking bench for timer_nch: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a behavioural reference model.
module tb_timer_nch;
  localparam int CH = 3;
  localparam int W  = 32;
`ifdef TIMER_NCH_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic            clk     = 1'b0;
  logic            rstn    = 1'b1;
  logic            we      = 1'b0;
  logic [1:0]      ch_sel  = '0;
  logic            reg_sel = 1'b0;
  logic [W-1:0]    wdata   = '0;
  logic [CH-1:0]   tick_i  = '0;
  logic [CH*W-1:0] count_o;
  logic [CH-1:0]   out_o;
  logic [CH-1:0]   irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  timer_nch #(.CH(CH), .W(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .we      (we),
    .ch_sel  (ch_sel),
    .reg_sel (reg_sel),
    .wdata   (wdata),
    .tick_i  (tick_i),
    .count_o (count_o),
    .out_o   (out_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic         rs;
    logic [W-1:0] wd;
    logic         tick;
    logic [W-1:0] cnt;
    logic         out;
    logic         irq;
  } vec_t;

  vec_t tbl[10];

  // Reference model state, one entry per channel.
  logic [W-1:0] m_cnt[CH];
  logic [W-1:0] m_load[CH];
  logic [1:0]   m_mode[CH];
  bit           m_act[CH];
  bit           m_out[CH];
  bit           m_ie[CH];
  bit           m_pend[CH];
  bit           m_irq[CH];
  bit           m_prev[CH];

  function automatic logic [W-1:0] cnt_of(input int n);
    return count_o[n*W +: W];
  endfunction

  function automatic vec_t mk(input bit w, input bit rs, input int wd, input bit t,
                              input int c, input bit o, input bit i);
    vec_t v;
    v.we = w; v.rs = rs; v.wd = W'(wd); v.tick = t; v.cnt = W'(c); v.out = o; v.irq = i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic rs, input logic [W-1:0] d);
    we = 1'b1; ch_sel = ch; reg_sel = rs; wdata = d;
  endtask

  task automatic idle_bus();
    we = 1'b0; ch_sel = '0; reg_sel = 1'b0; wdata = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_bus();
    tick_i = '0;
    step();
    step();
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      m_cnt[n] = '0; m_load[n] = '0; m_mode[n] = 2'd0; m_act[n] = 0; m_out[n] = 0;
      m_ie[n] = 0; m_pend[n] = 0; m_irq[n] = 0; m_prev[n] = 0;
    end
  endtask

  // Advances the model by one clk using the inputs currently driven.
  task automatic model_step();
    bit rise, hit, fire, clr;
    for (int n = 0; n < CH; n++) begin
      rise = tick_i[n] && !m_prev[n];
      hit  = we && (int'(ch_sel) == n);
      fire = 0;
      clr  = 0;
      m_prev[n] = tick_i[n];
      if (m_mode[n] == 2'd2) m_out[n] = 0;
      if (hit && !reg_sel) begin
        m_load[n] = wdata;
        m_cnt[n]  = wdata;
        m_out[n]  = 0;
        m_act[n]  = (m_mode[n] != 2'd0);
      end else if (hit) begin
        m_mode[n] = wdata[1:0];
        m_ie[n]   = wdata[2];
        clr       = wdata[3];
        m_act[n]  = (wdata[1:0] != 2'd0);
      end else if (m_act[n] && rise && m_load[n] != 0) begin
        if (m_cnt[n] == 1) begin
          fire = 1;
          if (m_mode[n] == 2'd1) begin
            m_cnt[n] = 0; m_act[n] = 0; m_out[n] = 1;
          end else begin
            m_cnt[n] = m_load[n];
            m_out[n] = (m_mode[n] == 2'd2) ? 1'b1 : !m_out[n];
          end
        end else begin
          m_cnt[n] = m_cnt[n] - 1;
        end
      end
      m_irq[n]  = (m_irq[n] && !clr) || m_pend[n];
      m_pend[n] = fire && m_ie[n];
    end
  endtask

  initial begin
    int pulses;
    logic [CH-1:0] eo, ei;

    // Asynchronous reset before any clk edge.
    #1 rstn = 1'b0;
    #1;
    for (int n = 0; n < CH; n++) chk("rst_async_cnt", cnt_of(n), '0);
    chk("rst_async_out", W'(out_o), '0);
    chk("rst_async_irq", W'(irq_o), '0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // One-shot on ch0.
    tbl[0] = mk(1, 1, 5, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 3, 0, 3, 0, 0);
    tbl[2] = mk(0, 0, 0, 1, 2, 0, 0);
    tbl[3] = mk(0, 0, 0, 0, 2, 0, 0);
    tbl[4] = mk(0, 0, 0, 1, 1, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 1, 0, 0);
    tbl[6] = mk(0, 0, 0, 1, 0, 1, 0);
    tbl[7] = mk(0, 0, 0, 0, 0, 1, 1);
    tbl[8] = mk(0, 0, 0, 1, 0, 1, 1);
    tbl[9] = mk(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) wr(2'd0, tbl[i].rs, tbl[i].wd);
      else idle_bus();
      tick_i = {2'b00, tbl[i].tick};
      step();
      chk($sformatf("os_cnt[%0d]", i), cnt_of(0), tbl[i].cnt);
      chk($sformatf("os_out[%0d]", i), W'(out_o[0]), W'(tbl[i].out));
      chk($sformatf("os_irq[%0d]", i), W'(irq_o[0]), W'(tbl[i].irq & IRQ_ON));
    end

    // Auto-reload on ch1.
    tick_i = '0;
    wr(2'd1, 1'b1, 2); step();
    wr(2'd1, 1'b0, 2); step();
    chk("ar_load", cnt_of(1), 2);
    idle_bus();
    pulses = 0;
    for (int e = 1; e <= 6; e++) begin
      tick_i[1] = 1'b1; step();
      chk("ar_cnt", cnt_of(1), (e % 2 != 0) ? W'(1) : W'(2));
      chk("ar_out", W'(out_o[1]), (e % 2 != 0) ? W'(0) : W'(1));
      pulses += int'(out_o[1]);
      tick_i[1] = 1'b0; step();
      chk("ar_out_lo", W'(out_o[1]), '0);
      pulses += int'(out_o[1]);
    end
    chk("ar_pulses", W'(pulses), W'(3));

    // Square-wave on ch2.
    wr(2'd2, 1'b1, 3); step();
    wr(2'd2, 1'b0, 4); step();
    chk("sq_load", cnt_of(2), 4);
    idle_bus();
    for (int e = 1; e <= 16; e++) begin
      tick_i[2] = 1'b1; step();
      chk("sq_out", W'(out_o[2]), W'((e / 4) % 2));
      chk("sq_cnt", cnt_of(2), (e % 4 == 0) ? W'(4) : W'(4 - e % 4));
      tick_i[2] = 1'b0; step();
    end
    chk("sq_final", W'(out_o[2]), '0);

    // Write/tick collision and clear/terminal collision on ch0.
    wr(2'd0, 1'b1, 'hD); step();
    chk("col_irq_clr", W'(irq_o[0]), '0);
    wr(2'd0, 1'b0, 5); step();
    chk("col_load5", cnt_of(0), 5);
    chk("col_out_clr", W'(out_o[0]), '0);
    wr(2'd0, 1'b0, 10); tick_i[0] = 1'b1; step();
    chk("col_load10", cnt_of(0), 10);
    idle_bus(); step();
    chk("col_hold_hi", cnt_of(0), 10);
    tick_i[0] = 1'b0; step();
    chk("col_hold_lo", cnt_of(0), 10);
    wr(2'd0, 1'b0, 1); step();
    idle_bus(); tick_i[0] = 1'b1; step();
    chk("col_term_cnt", cnt_of(0), 0);
    chk("col_term_out", W'(out_o[0]), 1);
    wr(2'd0, 1'b1, 'hC); tick_i[0] = 1'b0; step();
    chk("col_irq_keep", W'(irq_o[0]), W'(IRQ_ON));
    wr(2'd0, 1'b1, 'h8); step();
    chk("col_irq_gone", W'(irq_o[0]), '0);

    // Out-of-range channel select is ignored.
    wr(2'd3, 1'b0, 99); step();
    chk("oor_ch0", cnt_of(0), 0);
    chk("oor_ch1", cnt_of(1), 2);
    chk("oor_ch2", cnt_of(2), 4);

    // load = 0 in RUN: no counting, output held.
    wr(2'd1, 1'b0, 0); step();
    idle_bus();
    for (int e = 0; e < 2; e++) begin
      tick_i[1] = 1'b1; step();
      tick_i[1] = 1'b0; step();
    end
    chk("zl_cnt", cnt_of(1), 0);
    chk("zl_out", W'(out_o[1]), 0);

    // Reset mid-count with ticks held high through release.
    wr(2'd0, 1'b1, 1); step();
    wr(2'd0, 1'b0, 10); step();
    idle_bus();
    for (int e = 0; e < 3; e++) begin
      tick_i[0] = 1'b1; step();
      tick_i[0] = 1'b0; step();
    end
    chk("mid_cnt7", cnt_of(0), 7);
    tick_i = '1;
    #2 rstn = 1'b0;
    #1;
    for (int n = 0; n < CH; n++) chk("mid_rst_cnt", cnt_of(n), '0);
    chk("mid_rst_out", W'(out_o), '0);
    chk("mid_rst_irq", W'(irq_o), '0);
    step(); step();
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("rel_first_edge", cnt_of(0), '0);
    tick_i = '0; step();
    tick_i = '1; step();
    for (int n = 0; n < CH; n++) chk("rel_idle_cnt", cnt_of(n), '0);
    chk("rel_idle_out", W'(out_o), '0);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      tick_i = CH'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        we      = 1'b1;
        ch_sel  = 2'($urandom_range(0, 3));
        reg_sel = 1'($urandom_range(0, 1));
        wdata   = reg_sel ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 5));
      end else begin
        idle_bus();
      end
      model_step();
      step();
      for (int n = 0; n < CH; n++) begin
        chk($sformatf("rnd_cnt%0d@%0d", n, c), cnt_of(n), m_cnt[n]);
        eo[n] = m_out[n];
        ei[n] = m_irq[n] & IRQ_ON;
      end
      chk($sformatf("rnd_out@%0d", c), W'(out_o), W'(eo));
      chk($sformatf("rnd_irq@%0d", c), W'(irq_o), W'(ei));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
